// File: rtl/rggen_apb_bridge_pkg.sv
// Shared types and helpers for the command-to-APB3 master bridge.
package rggen_apb_bridge_pkg;

   localparam int unsigned STATUS_WIDTH = 2;

   // Transfer sequencing states
   typedef enum logic [1:0] {
      STATE_IDLE     = 2'd0,
      STATE_SETUP    = 2'd1,
      STATE_ACCESS   = 2'd2,
      STATE_RESPONSE = 2'd3
   } state_e;

   // Response status codes as seen on o_rsp_status
   typedef enum logic [STATUS_WIDTH-1:0] {
      STATUS_OK      = 2'd0,
      STATUS_SLVERR  = 2'd1,
      STATUS_TIMEOUT = 2'd2
   } status_e;

   // Bits needed to hold 0..limit without wrapping
   function automatic int unsigned timeout_count_width(input int unsigned limit);
      if (limit < 1) begin
         return 1;
      end
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/rggen_apb_if.sv
// APB3 bus bundle with master and slave views.
interface rggen_apb_if #(
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned DATA_WIDTH    = 32
);
   logic                     psel;
   logic                     penable;
   logic [ADDRESS_WIDTH-1:0] paddr;
   logic                     pwrite;
   logic [DATA_WIDTH-1:0]    pwdata;
   logic [DATA_WIDTH-1:0]    prdata;
   logic                     pready;
   logic                     pslverr;

   modport master (
      output psel, penable, paddr, pwrite, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, paddr, pwrite, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/rggen_apb_timeout_counter.sv
// Saturating wait-state counter; flags the cycle in which the limit is reached.
module rggen_apb_timeout_counter
   import rggen_apb_bridge_pkg::*;
#(
   parameter int unsigned LIMIT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_count_en,
   output logic o_expired_c
);

   localparam int unsigned CW = timeout_count_width(LIMIT);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Clear wins; otherwise count enabled cycles and stick at the limit
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_count_en && (count_q != CW'(LIMIT))) begin
         count_d = count_q + CW'(1);
      end
   end

   // The current enabled cycle is the LIMIT-th one
   assign o_expired_c = i_count_en && (count_q == CW'(LIMIT - 1));

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/rggen_apb_master_bridge.sv
// Converts single valid/ready commands into APB3 transfers with a response channel.
module rggen_apb_master_bridge
   import rggen_apb_bridge_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   input  logic                     i_cmd_write,
   input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
   input  logic [DATA_WIDTH-1:0]    i_cmd_wdata,
   rggen_apb_if.master              apb_if,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [STATUS_WIDTH-1:0]  o_rsp_status,
   output logic [DATA_WIDTH-1:0]    o_rsp_rdata
);

   state_e                   state_q,     state_d;
   logic                     cmd_ready_q, cmd_ready_d;
   logic                     psel_q,      psel_d;
   logic                     penable_q,   penable_d;
   logic                     pwrite_q,    pwrite_d;
   logic [ADDRESS_WIDTH-1:0] paddr_q,     paddr_d;
   logic [DATA_WIDTH-1:0]    pwdata_q,    pwdata_d;
   logic                     rsp_valid_q, rsp_valid_d;
   status_e                  status_q,    status_d;
   logic [DATA_WIDTH-1:0]    rdata_q,     rdata_d;

   logic clear_c;
   logic count_en_c;
   logic expired_c;

   // Wait-state timeout, absent when the limit is zero
   if (TIMEOUT_CYCLES != 0) begin : g_timeout
      rggen_apb_timeout_counter #(
         .LIMIT (TIMEOUT_CYCLES)
      ) u_timeout (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_clear     (clear_c),
         .i_count_en  (count_en_c),
         .o_expired_c (expired_c)
      );
   end else begin : g_no_timeout
      assign expired_c = 1'b0;
   end

   // Next-state and next-output logic; slave inputs only matter in ACCESS
   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      status_d    = status_q;
      rdata_d     = rdata_q;
      clear_c     = 1'b0;
      count_en_c  = 1'b0;

      unique case (state_q)
         STATE_IDLE: begin
            if (i_cmd_valid && cmd_ready_q) begin
               state_d   = STATE_SETUP;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = i_cmd_write;
               paddr_d   = i_cmd_address;
               pwdata_d  = i_cmd_wdata;
               clear_c   = 1'b1;
            end
         end
         STATE_SETUP: begin
            state_d   = STATE_ACCESS;
            penable_d = 1'b1;
         end
         STATE_ACCESS: begin
            if (apb_if.pready) begin
               state_d     = STATE_RESPONSE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               status_d    = apb_if.pslverr ? STATUS_SLVERR : STATUS_OK;
               rdata_d     = (!apb_if.pslverr && !pwrite_q) ? apb_if.prdata : '0;
            end else begin
               count_en_c = 1'b1;
               if (expired_c) begin
                  state_d     = STATE_RESPONSE;
                  psel_d      = 1'b0;
                  penable_d   = 1'b0;
                  rsp_valid_d = 1'b1;
                  status_d    = STATUS_TIMEOUT;
                  rdata_d     = '0;
               end
            end
         end
         STATE_RESPONSE: begin
            if (i_rsp_ready) begin
               state_d     = STATE_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = STATE_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == STATE_IDLE);
   end

   // State and registered outputs; reset drops any transfer in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= STATE_IDLE;
         cmd_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         status_q    <= STATUS_OK;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         status_q    <= status_d;
         rdata_q     <= rdata_d;
      end
   end

   assign o_cmd_ready    = cmd_ready_q;
   assign apb_if.psel    = psel_q;
   assign apb_if.penable = penable_q;
   assign apb_if.pwrite  = pwrite_q;
   assign apb_if.paddr   = paddr_q;
   assign apb_if.pwdata  = pwdata_q;
   assign o_rsp_valid    = rsp_valid_q;
   assign o_rsp_status   = status_q;
   assign o_rsp_rdata    = rdata_q;

endmodule

// File: tb/tb_rggen_apb_master_bridge.sv
// Directed bench for the APB master bridge with a hand-driven APB slave.
module tb_rggen_apb_master_bridge;

   logic        clk;
   logic        rst_n;
   logic        i_cmd_valid;
   logic        o_cmd_ready;
   logic        i_cmd_write;
   logic [15:0] i_cmd_address;
   logic [31:0] i_cmd_wdata;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [1:0]  o_rsp_status;
   logic [31:0] o_rsp_rdata;

   int checks = 0;
   int errors = 0;

   rggen_apb_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) apb_bus ();

   rggen_apb_master_bridge #(
      .ADDRESS_WIDTH  (16),
      .DATA_WIDTH     (32),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_cmd_valid   (i_cmd_valid),
      .o_cmd_ready   (o_cmd_ready),
      .i_cmd_write   (i_cmd_write),
      .i_cmd_address (i_cmd_address),
      .i_cmd_wdata   (i_cmd_wdata),
      .apb_if        (apb_bus.master),
      .o_rsp_valid   (o_rsp_valid),
      .i_rsp_ready   (i_rsp_ready),
      .o_rsp_status  (o_rsp_status),
      .o_rsp_rdata   (o_rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one command at a negedge; returns one cycle after the accept edge
   task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d);
      int n;
      n = 0;
      while (!o_cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("issue_ready", 64'(o_cmd_ready), 64'd1);
      i_cmd_valid   = 1'b1;
      i_cmd_write   = wr;
      i_cmd_address = a;
      i_cmd_wdata   = d;
      @(negedge clk);
      i_cmd_valid   = 1'b0;
   endtask

   // Consume the pending response
   task automatic ack();
      i_rsp_ready = 1'b1;
      @(negedge clk);
      i_rsp_ready = 1'b0;
   endtask

   initial begin
      int acc;
      int n;
      rst_n          = 1'b1;
      i_cmd_valid    = 1'b0;
      i_cmd_write    = 1'b0;
      i_cmd_address  = '0;
      i_cmd_wdata    = '0;
      i_rsp_ready    = 1'b0;
      apb_bus.pready  = 1'b1;
      apb_bus.pslverr = 1'b0;
      apb_bus.prdata  = 32'hFFFF_FFFF;
      #2 rst_n = 1'b0;
      #1;
      // Reset values
      chk("rst_psel",    64'(apb_bus.psel),    64'd0);
      chk("rst_penable", 64'(apb_bus.penable), 64'd0);
      chk("rst_pwrite",  64'(apb_bus.pwrite),  64'd0);
      chk("rst_paddr",   64'(apb_bus.paddr),   64'd0);
      chk("rst_pwdata",  64'(apb_bus.pwdata),  64'd0);
      chk("rst_rvalid",  64'(o_rsp_valid),     64'd0);
      chk("rst_status",  64'(o_rsp_status),    64'd0);
      chk("rst_rdata",   64'(o_rsp_rdata),     64'd0);
      chk("rst_cready",  64'(o_cmd_ready),     64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_cready", 64'(o_cmd_ready), 64'd1);

      // Write 0x0004 / 0xDEADBEEF, zero-wait slave
      apb_bus.pready = 1'b1;
      issue(1'b1, 16'h0004, 32'hDEAD_BEEF);
      chk("w1_setup_psel",    64'(apb_bus.psel),    64'd1);
      chk("w1_setup_penable", 64'(apb_bus.penable), 64'd0);
      chk("w1_setup_paddr",   64'(apb_bus.paddr),   64'h0004);
      chk("w1_setup_pwrite",  64'(apb_bus.pwrite),  64'd1);
      chk("w1_setup_pwdata",  64'(apb_bus.pwdata),  64'hDEAD_BEEF);
      chk("w1_setup_cready",  64'(o_cmd_ready),     64'd0);
      @(negedge clk);
      chk("w1_access_psel",    64'(apb_bus.psel),    64'd1);
      chk("w1_access_penable", 64'(apb_bus.penable), 64'd1);
      chk("w1_access_paddr",   64'(apb_bus.paddr),   64'h0004);
      chk("w1_access_rvalid",  64'(o_rsp_valid),     64'd0);
      @(negedge clk);
      chk("w1_rsp_valid",   64'(o_rsp_valid),     64'd1);
      chk("w1_rsp_status",  64'(o_rsp_status),    64'd0);
      chk("w1_rsp_rdata",   64'(o_rsp_rdata),     64'd0);
      chk("w1_rsp_psel",    64'(apb_bus.psel),    64'd0);
      chk("w1_rsp_penable", 64'(apb_bus.penable), 64'd0);
      ack();
      chk("w1_done_rvalid", 64'(o_rsp_valid), 64'd0);
      chk("w1_done_cready", 64'(o_cmd_ready), 64'd1);

      // Read 0x0008 with two wait states
      apb_bus.pready = 1'b0;
      apb_bus.prdata = 32'h0001_0001;
      issue(1'b0, 16'h0008, 32'h0);
      chk("r2_setup_pwrite", 64'(apb_bus.pwrite), 64'd0);
      @(negedge clk);
      chk("r2_wait1_penable", 64'(apb_bus.penable), 64'd1);
      @(negedge clk);
      chk("r2_wait2_psel",   64'(apb_bus.psel),   64'd1);
      chk("r2_wait2_rvalid", 64'(o_rsp_valid),    64'd0);
      @(negedge clk);
      chk("r2_acc3_rvalid",  64'(o_rsp_valid),    64'd0);
      chk("r2_acc3_paddr",   64'(apb_bus.paddr),  64'h0008);
      apb_bus.pready = 1'b1;
      @(negedge clk);
      chk("r2_rsp_valid",  64'(o_rsp_valid),  64'd1);
      chk("r2_rsp_status", 64'(o_rsp_status), 64'd0);
      chk("r2_rsp_rdata",  64'(o_rsp_rdata),  64'h0001_0001);
      ack();

      // Read with slave error
      apb_bus.pready  = 1'b1;
      apb_bus.pslverr = 1'b1;
      apb_bus.prdata  = 32'h1234_5678;
      issue(1'b0, 16'h000C, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("e3_rsp_valid",  64'(o_rsp_valid),  64'd1);
      chk("e3_rsp_status", 64'(o_rsp_status), 64'd1);
      chk("e3_rsp_rdata",  64'(o_rsp_rdata),  64'd0);
      ack();
      apb_bus.pslverr = 1'b0;

      // Timeout after four ACCESS cycles
      apb_bus.pready = 1'b0;
      issue(1'b0, 16'h0040, 32'h0);
      acc = 0;
      n = 0;
      while (!o_rsp_valid && n < 20) begin
         if (apb_bus.psel && apb_bus.penable) acc++;
         @(negedge clk);
         n++;
      end
      chk("t4_rsp_valid",   64'(o_rsp_valid),     64'd1);
      chk("t4_access_cnt",  64'(acc),             64'd4);
      chk("t4_psel_drop",   64'(apb_bus.psel),    64'd0);
      chk("t4_penable",     64'(apb_bus.penable), 64'd0);
      chk("t4_status",      64'(o_rsp_status),    64'd2);
      chk("t4_rdata",       64'(o_rsp_rdata),     64'd0);
      ack();

      // Follow-up read: pready on the 4th ACCESS cycle beats the timeout
      issue(1'b0, 16'h0044, 32'h0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("t4b_still_access", 64'(apb_bus.penable), 64'd1);
      apb_bus.pready = 1'b1;
      apb_bus.prdata = 32'h0BAD_F00D;
      @(negedge clk);
      chk("t4b_rsp_valid",  64'(o_rsp_valid),  64'd1);
      chk("t4b_rsp_status", 64'(o_rsp_status), 64'd0);
      chk("t4b_rsp_rdata",  64'(o_rsp_rdata),  64'h0BAD_F00D);
      ack();

      // Response back-pressure, then accept on the cycle after the handshake
      apb_bus.prdata = 32'hCAFE_F00D;
      issue(1'b0, 16'h0020, 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("bp_rsp_valid", 64'(o_rsp_valid), 64'd1);
      apb_bus.prdata = 32'h0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold_valid",  64'(o_rsp_valid),  64'd1);
         chk("bp_hold_rdata",  64'(o_rsp_rdata),  64'hCAFE_F00D);
         chk("bp_hold_status", 64'(o_rsp_status), 64'd0);
         chk("bp_hold_cready", 64'(o_cmd_ready),  64'd0);
      end
      i_rsp_ready   = 1'b1;
      i_cmd_valid   = 1'b1;
      i_cmd_write   = 1'b1;
      i_cmd_address = 16'h0024;
      i_cmd_wdata   = 32'h1111_2222;
      @(negedge clk);
      i_rsp_ready = 1'b0;
      chk("bp_after_rvalid", 64'(o_rsp_valid),  64'd0);
      chk("bp_after_cready", 64'(o_cmd_ready),  64'd1);
      chk("bp_after_psel",   64'(apb_bus.psel), 64'd0);
      @(negedge clk);
      i_cmd_valid = 1'b0;
      chk("bp_next_psel",   64'(apb_bus.psel),   64'd1);
      chk("bp_next_paddr",  64'(apb_bus.paddr),  64'h0024);
      chk("bp_next_pwdata", 64'(apb_bus.pwdata), 64'h1111_2222);
      @(negedge clk);
      @(negedge clk);
      chk("bp_next_rvalid", 64'(o_rsp_valid),  64'd1);
      chk("bp_next_status", 64'(o_rsp_status), 64'd0);
      chk("bp_next_rdata",  64'(o_rsp_rdata),  64'd0);
      ack();

      // Reset in the middle of ACCESS
      apb_bus.pready = 1'b0;
      issue(1'b1, 16'h0030, 32'hAAAA_5555);
      @(negedge clk);
      chk("rs_access_penable", 64'(apb_bus.penable), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rs_psel",    64'(apb_bus.psel),    64'd0);
      chk("rs_penable", 64'(apb_bus.penable), 64'd0);
      chk("rs_rvalid",  64'(o_rsp_valid),     64'd0);
      chk("rs_cready",  64'(o_cmd_ready),     64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      apb_bus.pready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("rs_no_rsp",  64'(o_rsp_valid),  64'd0);
      chk("rs_no_psel", 64'(apb_bus.psel), 64'd0);
      issue(1'b1, 16'h0000, 32'h0000_0001);
      chk("rs_w_paddr", 64'(apb_bus.paddr), 64'h0000);
      chk("rs_w_psel",  64'(apb_bus.psel),  64'd1);
      @(negedge clk);
      @(negedge clk);
      chk("rs_w_rvalid", 64'(o_rsp_valid),  64'd1);
      chk("rs_w_status", 64'(o_rsp_status), 64'd0);
      chk("rs_w_rdata",  64'(o_rsp_rdata),  64'd0);
      ack();
      chk("rs_w_done", 64'(o_cmd_ready), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
